// File: rtl/core_161c.sv
// core_161c -- four-port 16K x 36 memory bank controller
//
// Purpose:
//   Serves read, write, read-modify-write and null memory cycles from up to
//   four bus ports. A port is selected when its bank select matches the
//   port's memsel parameter and the request is not a fast-memory access.
//   Simultaneous requests are granted with fixed priority p0 > p1 > p2 > p3.
//   Optional single-step mode parks the controller after each completed cycle
//   until a rising edge on sw_restart.
//
// Ports:
//   clk                   system clock, rising-edge
//   reset                 asynchronous, active-low reset
//   power                 1 = operational, 0 = idle with all outputs forced to 0
//   sw_single_step        stop after each completed memory cycle
//   sw_restart            rising edge resumes from a single-step stop
//   membus_*_pN (N=0..3)  per-port request inputs (rq_cyc, rd_rq, wr_rq, sel,
//                         fmc_select, ma, wr_rs, mb_in) and responses
//                         (addr_ack, rd_rs, mb_out); responses are 0 for
//                         every port that does not own the current cycle
//
// States:
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | waiting for a selected request
//   S_ACK     | addr_ack pulse to the owning port
//   S_RD_WAIT | storage read in progress
//   S_RD_RS   | rd_rs pulse, read word on mb_out
//   S_WR_WAIT | waiting for wr_rs from the owning port
//   S_DONE    | write stored, one cycle before returning to idle
//   S_STOP    | single-step halt, waiting for sw_restart rising edge

module core_161c #(
    parameter logic [3:0] memsel_p0 = 4'd0,
    parameter logic [3:0] memsel_p1 = 4'd0,
    parameter logic [3:0] memsel_p2 = 4'd0,
    parameter logic [3:0] memsel_p3 = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        power,
    input  logic        sw_single_step,
    input  logic        sw_restart,

    input  logic        membus_rq_cyc_p0,
    input  logic        membus_rd_rq_p0,
    input  logic        membus_wr_rq_p0,
    input  logic [3:0]  membus_sel_p0,
    input  logic        membus_fmc_select_p0,
    input  logic [14:0] membus_ma_p0,
    input  logic        membus_wr_rs_p0,
    input  logic [35:0] membus_mb_in_p0,
    output logic        membus_addr_ack_p0,
    output logic        membus_rd_rs_p0,
    output logic [35:0] membus_mb_out_p0,

    input  logic        membus_rq_cyc_p1,
    input  logic        membus_rd_rq_p1,
    input  logic        membus_wr_rq_p1,
    input  logic [3:0]  membus_sel_p1,
    input  logic        membus_fmc_select_p1,
    input  logic [14:0] membus_ma_p1,
    input  logic        membus_wr_rs_p1,
    input  logic [35:0] membus_mb_in_p1,
    output logic        membus_addr_ack_p1,
    output logic        membus_rd_rs_p1,
    output logic [35:0] membus_mb_out_p1,

    input  logic        membus_rq_cyc_p2,
    input  logic        membus_rd_rq_p2,
    input  logic        membus_wr_rq_p2,
    input  logic [3:0]  membus_sel_p2,
    input  logic        membus_fmc_select_p2,
    input  logic [14:0] membus_ma_p2,
    input  logic        membus_wr_rs_p2,
    input  logic [35:0] membus_mb_in_p2,
    output logic        membus_addr_ack_p2,
    output logic        membus_rd_rs_p2,
    output logic [35:0] membus_mb_out_p2,

    input  logic        membus_rq_cyc_p3,
    input  logic        membus_rd_rq_p3,
    input  logic        membus_wr_rq_p3,
    input  logic [3:0]  membus_sel_p3,
    input  logic        membus_fmc_select_p3,
    input  logic [14:0] membus_ma_p3,
    input  logic        membus_wr_rs_p3,
    input  logic [35:0] membus_mb_in_p3,
    output logic        membus_addr_ack_p3,
    output logic        membus_rd_rs_p3,
    output logic [35:0] membus_mb_out_p3
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_RD_WAIT,
        S_RD_RS,
        S_WR_WAIT,
        S_DONE,
        S_STOP
    } state_t;

    // Per-port inputs gathered into arrays so the core logic can index by port.
    logic [3:0]  rq_cyc;
    logic [3:0]  rd_rq;
    logic [3:0]  wr_rq;
    logic [3:0]  fmc_sel;
    logic [3:0]  wr_rs;
    logic [3:0]  sel    [4];
    logic [3:0]  memsel [4];
    logic [13:0] ma     [4];
    logic [35:0] mb_in  [4];

    assign rq_cyc  = {membus_rq_cyc_p3, membus_rq_cyc_p2, membus_rq_cyc_p1, membus_rq_cyc_p0};
    assign rd_rq   = {membus_rd_rq_p3, membus_rd_rq_p2, membus_rd_rq_p1, membus_rd_rq_p0};
    assign wr_rq   = {membus_wr_rq_p3, membus_wr_rq_p2, membus_wr_rq_p1, membus_wr_rq_p0};
    assign fmc_sel = {membus_fmc_select_p3, membus_fmc_select_p2,
                      membus_fmc_select_p1, membus_fmc_select_p0};
    assign wr_rs   = {membus_wr_rs_p3, membus_wr_rs_p2, membus_wr_rs_p1, membus_wr_rs_p0};

    assign sel[0]    = membus_sel_p0;
    assign sel[1]    = membus_sel_p1;
    assign sel[2]    = membus_sel_p2;
    assign sel[3]    = membus_sel_p3;
    assign memsel[0] = memsel_p0;
    assign memsel[1] = memsel_p1;
    assign memsel[2] = memsel_p2;
    assign memsel[3] = memsel_p3;
    // Address bit 21 (vector MSB) is outside the 16K-word bank and is ignored.
    assign ma[0]     = membus_ma_p0[13:0];
    assign ma[1]     = membus_ma_p1[13:0];
    assign ma[2]     = membus_ma_p2[13:0];
    assign ma[3]     = membus_ma_p3[13:0];
    assign mb_in[0]  = membus_mb_in_p0;
    assign mb_in[1]  = membus_mb_in_p1;
    assign mb_in[2]  = membus_mb_in_p2;
    assign mb_in[3]  = membus_mb_in_p3;

    logic unused_ma_msb;
    assign unused_ma_msb = ^{membus_ma_p0[14], membus_ma_p1[14],
                             membus_ma_p2[14], membus_ma_p3[14]};

    state_t      state_q, state_d;
    logic [1:0]  port_q, port_d;
    logic [13:0] addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        restart_q, restart_d;
    logic [35:0] rdata_q;
    logic        mem_we;
    logic        cycle_end;

    logic [35:0] mem_q [16384];

    logic [3:0]  port_sel;
    logic [1:0]  grant_idx;

    // Fixed priority: scanning from p3 down lets the lowest index win.
    always_comb begin
        grant_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            port_sel[i] = power && rq_cyc[i] && (sel[i] == memsel[i]) && !fmc_sel[i];
        end
        for (int i = 3; i >= 0; i--) begin
            if (port_sel[i]) grant_idx = 2'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        restart_d = sw_restart;
        mem_we    = 1'b0;
        cycle_end = 1'b0;
        if (!power) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|port_sel) begin
                        state_d = S_ACK;
                        port_d  = grant_idx;
                        addr_d  = ma[grant_idx];
                        rd_d    = rd_rq[grant_idx];
                        wr_d    = wr_rq[grant_idx];
                    end
                end
                S_ACK: begin
                    if (rd_q)      state_d = S_RD_WAIT;
                    else if (wr_q) state_d = S_WR_WAIT;
                    else           cycle_end = 1'b1;
                end
                S_RD_WAIT: state_d = S_RD_RS;
                S_RD_RS: begin
                    if (wr_q) state_d = S_WR_WAIT;
                    else      cycle_end = 1'b1;
                end
                S_WR_WAIT: begin
                    if (wr_rs[port_q]) begin
                        mem_we  = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: cycle_end = 1'b1;
                S_STOP: begin
                    if (sw_restart && !restart_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
            if (cycle_end) state_d = sw_single_step ? S_STOP : S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            port_q    <= 2'd0;
            addr_q    <= 14'd0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            restart_q <= restart_d;
        end
    end

    // Storage is not reset; the read word is captured as RD_WAIT ends so it is
    // presented from the rd_rs cycle onward, before any RMW write lands.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[addr_q] <= mb_in[port_q];
        if (state_q == S_RD_WAIT) rdata_q <= mem_q[addr_q];
    end

    logic        ack_v [4];
    logic        rs_v  [4];
    logic [35:0] mbo_v [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ack_v[i] = power && (port_q == 2'(i)) && (state_q == S_ACK);
            rs_v[i]  = power && (port_q == 2'(i)) && (state_q == S_RD_RS);
            mbo_v[i] = '0;
            if (power && (port_q == 2'(i)) && rd_q &&
                (state_q == S_RD_RS || state_q == S_WR_WAIT || state_q == S_DONE)) begin
                mbo_v[i] = rdata_q;
            end
        end
    end

    assign membus_addr_ack_p0 = ack_v[0];
    assign membus_addr_ack_p1 = ack_v[1];
    assign membus_addr_ack_p2 = ack_v[2];
    assign membus_addr_ack_p3 = ack_v[3];
    assign membus_rd_rs_p0    = rs_v[0];
    assign membus_rd_rs_p1    = rs_v[1];
    assign membus_rd_rs_p2    = rs_v[2];
    assign membus_rd_rs_p3    = rs_v[3];
    assign membus_mb_out_p0   = mbo_v[0];
    assign membus_mb_out_p1   = mbo_v[1];
    assign membus_mb_out_p2   = mbo_v[2];
    assign membus_mb_out_p3   = mbo_v[3];

endmodule

// File: tb/tb_core_161c.sv
// tb_core_161c -- bench for core_161c: directed bus cycles plus randomized
// traffic, checked each cycle against a transaction-level reference model.
module tb_core_161c;
    localparam logic [3:0] MS0 = 4'd0;
    localparam logic [3:0] MS1 = 4'd5;
    localparam logic [3:0] MS2 = 4'd0;
    localparam logic [3:0] MS3 = 4'd9;

    logic clk = 1'b0, reset = 1'b0, power = 1'b1;
    logic sw_single_step = 1'b0, sw_restart = 1'b0;
    logic [3:0] rq = '0, rdq = '0, wrq = '0, fmc = '0, wrs = '0;
    logic [3:0][3:0]  sel   = '0;
    logic [3:0][14:0] ma    = '0;
    logic [3:0][35:0] mb_in = '0;
    logic [3:0] ack, rs;
    logic [3:0][35:0] mb_out;
    logic [3:0] active = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    core_161c #(.memsel_p0(MS0), .memsel_p1(MS1), .memsel_p2(MS2), .memsel_p3(MS3)) dut (
        .clk(clk), .reset(reset), .power(power),
        .sw_single_step(sw_single_step), .sw_restart(sw_restart),
        .membus_rq_cyc_p0(rq[0]), .membus_rd_rq_p0(rdq[0]), .membus_wr_rq_p0(wrq[0]),
        .membus_sel_p0(sel[0]), .membus_fmc_select_p0(fmc[0]), .membus_ma_p0(ma[0]),
        .membus_wr_rs_p0(wrs[0]), .membus_mb_in_p0(mb_in[0]),
        .membus_addr_ack_p0(ack[0]), .membus_rd_rs_p0(rs[0]), .membus_mb_out_p0(mb_out[0]),
        .membus_rq_cyc_p1(rq[1]), .membus_rd_rq_p1(rdq[1]), .membus_wr_rq_p1(wrq[1]),
        .membus_sel_p1(sel[1]), .membus_fmc_select_p1(fmc[1]), .membus_ma_p1(ma[1]),
        .membus_wr_rs_p1(wrs[1]), .membus_mb_in_p1(mb_in[1]),
        .membus_addr_ack_p1(ack[1]), .membus_rd_rs_p1(rs[1]), .membus_mb_out_p1(mb_out[1]),
        .membus_rq_cyc_p2(rq[2]), .membus_rd_rq_p2(rdq[2]), .membus_wr_rq_p2(wrq[2]),
        .membus_sel_p2(sel[2]), .membus_fmc_select_p2(fmc[2]), .membus_ma_p2(ma[2]),
        .membus_wr_rs_p2(wrs[2]), .membus_mb_in_p2(mb_in[2]),
        .membus_addr_ack_p2(ack[2]), .membus_rd_rs_p2(rs[2]), .membus_mb_out_p2(mb_out[2]),
        .membus_rq_cyc_p3(rq[3]), .membus_rd_rq_p3(rdq[3]), .membus_wr_rq_p3(wrq[3]),
        .membus_sel_p3(sel[3]), .membus_fmc_select_p3(fmc[3]), .membus_ma_p3(ma[3]),
        .membus_wr_rs_p3(wrs[3]), .membus_mb_in_p3(mb_in[3]),
        .membus_addr_ack_p3(ack[3]), .membus_rd_rs_p3(rs[3]), .membus_mb_out_p3(mb_out[3])
    );

    function automatic logic [3:0] ms(int p);
        case (p)
            0:       return MS0;
            1:       return MS1;
            2:       return MS2;
            default: return MS3;
        endcase
    endfunction

    // Reference model: a cycle is described by its owner, its kind and its
    // age (cycles since the accepting edge, 1 = addr_ack cycle).
    bit          m_busy = 0, m_stopped = 0, m_rprev = 0;
    bit          m_rd = 0, m_wr = 0, m_stored = 0, m_wvld = 0;
    int          m_age = 0, m_own = 0;
    logic [13:0] m_addr = '0;
    logic [35:0] m_word = '0;
    logic [35:0] m_mem [16384];
    bit          m_vld [16384];

    task automatic model_step();
        bit redge, fin;
        redge = sw_restart && !m_rprev;
        m_rprev = sw_restart;
        if (!power) begin
            m_busy = 0;
            m_stopped = 0;
        end else if (m_stopped) begin
            if (redge) m_stopped = 0;
        end else if (!m_busy) begin
            for (int p = 0; p < 4; p++) begin
                if (rq[p] && sel[p] == ms(p) && !fmc[p]) begin
                    m_busy = 1; m_age = 1; m_own = p; m_stored = 0;
                    m_rd = rdq[p]; m_wr = wrq[p]; m_addr = ma[p][13:0];
                    break;
                end
            end
        end else begin
            fin = 0;
            if (m_stored) fin = 1;
            else if (!m_wr) fin = (m_age == (m_rd ? 3 : 1));
            else if (m_age >= (m_rd ? 4 : 2) && wrs[m_own]) begin
                m_mem[m_addr] = mb_in[m_own];
                m_vld[m_addr] = 1;
                m_stored = 1;
            end
            if (fin) begin
                m_busy = 0;
                if (sw_single_step) m_stopped = 1;
            end else begin
                m_age++;
                if (m_rd && m_age == 3) begin
                    m_word = m_mem[m_addr];
                    m_wvld = m_vld[m_addr];
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_busy = 0; m_stopped = 0; m_rprev = 0;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle compare, sampled 2 time units after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int p = 0; p < 4; p++) begin
                bit e_ack, e_rs, e_mbv, mb_ok;
                logic [35:0] e_mb;
                e_ack = power && m_busy && m_own == p && m_age == 1;
                e_rs  = power && m_busy && m_own == p && m_rd && m_age == 3;
                e_mbv = power && m_busy && m_own == p && m_rd && m_age >= 3;
                e_mb  = e_mbv ? m_word : 36'd0;
                mb_ok = (e_mbv && !m_wvld) ? 1'b1 : (mb_out[p] === e_mb);
                vectors++;
                if (ack[p] !== e_ack || rs[p] !== e_rs || !mb_ok) begin
                    miscompares++;
                    $display("FAIL cycle p%0d @%0t: ack=%b rs=%b mb=%o, expected ack=%b rs=%b mb=%o",
                             p, $time, ack[p], rs[p], mb_out[p], e_ack, e_rs, e_mb);
                end
            end
        end
    end

    task automatic chk(string name, logic [35:0] act, logic [35:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0o, expected %0o", name, act, exp);
        end
    endtask

    // One falling edge; ports not in use by a directed sequence get random
    // traffic that can never select this bank.
    task automatic tick();
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            if (!active[p]) begin
                rq[p]    = 1'($urandom_range(1, 0));
                fmc[p]   = 1'($urandom_range(1, 0));
                sel[p]   = fmc[p] ? 4'($urandom) : (ms(p) ^ 4'($urandom_range(15, 1)));
                rdq[p]   = 1'($urandom_range(1, 0));
                wrq[p]   = 1'($urandom_range(1, 0));
                wrs[p]   = 1'($urandom_range(1, 0));
                ma[p]    = 15'($urandom);
                mb_in[p] = {4'($urandom), 32'($urandom)};
            end
        end
    endtask

    task automatic wait_bit(int p, bit want_rs, string name, output int n, output bit ok);
        n = 0;
        ok = 0;
        while (!ok && n < 40) begin
            tick();
            n++;
            ok = want_rs ? rs[p] : ack[p];
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: p%0d %s not seen within 40 cycles", name, p, want_rs ? "rd_rs" : "addr_ack");
        end
    endtask

    task automatic setup_port(int p, bit rd, bit wr, logic [13:0] a);
        active[p] = 1; rq[p] = 1; sel[p] = ms(p); fmc[p] = 0;
        rdq[p] = rd; wrq[p] = wr; ma[p] = {1'($urandom), a}; wrs[p] = 0;
    endtask

    task automatic do_cycle(int p, bit rd, bit wr, logic [13:0] a, logic [35:0] d, int dly,
                            output logic [35:0] rdat, output int lat);
        int n;
        bit ok;
        setup_port(p, rd, wr, a);
        rdat = '0;
        wait_bit(p, 0, "cycle_ack", lat, ok);
        rq[p] = 0;
        if (ok && rd) begin
            wait_bit(p, 1, "cycle_rd_rs", n, ok);
            rdat = mb_out[p];
        end
        if (ok && wr) begin
            repeat (1 + dly) tick();
            wrs[p] = 1; mb_in[p] = d;
            tick();
            wrs[p] = 0;
        end
        tick();
        active[p] = 0;
    endtask

    initial begin
        logic [35:0] rdat;
        int lat, n;
        bit ok;

        repeat (3) tick();
        chk("reset_ack", {32'd0, ack}, 36'd0);
        chk("reset_rs", {32'd0, rs}, 36'd0);
        chk("reset_mb", mb_out[0] | mb_out[1] | mb_out[2] | mb_out[3], 36'd0);
        reset = 1;
        tick();

        do_cycle(0, 0, 1, 14'o20, 36'o102030405060, 2, rdat, lat);
        chk("write_ack_lat", 36'(lat), 36'd1);
        do_cycle(0, 1, 0, 14'o20, 36'd0, 0, rdat, lat);
        chk("read20", rdat, 36'o102030405060);
        do_cycle(0, 1, 0, 14'o20, 36'd0, 0, rdat, lat);
        chk("reread20", rdat, 36'o102030405060);

        do_cycle(0, 0, 1, 14'd3, 36'o1234, 0, rdat, lat);
        do_cycle(0, 1, 1, 14'd3, 36'o1235, 1, rdat, lat);
        chk("rmw_old", rdat, 36'o1234);
        do_cycle(0, 1, 0, 14'd3, 36'd0, 0, rdat, lat);
        chk("rmw_new", rdat, 36'o1235);

        setup_port(0, 1, 0, 14'o20);
        setup_port(2, 1, 0, 14'd3);
        wait_bit(0, 0, "prio_p0_ack", n, ok);
        chk("prio_p2_held", {35'd0, ack[2]}, 36'd0);
        rq[0] = 0;
        wait_bit(2, 0, "prio_p2_ack", n, ok);
        chk("prio_gap", 36'(n), 36'd4);
        rq[2] = 0;
        wait_bit(2, 1, "prio_p2_rs", n, ok);
        chk("prio_p2_data", mb_out[2], 36'o1235);
        tick();
        active = '0;

        active[1] = 1; rq[1] = 1; sel[1] = 4'd4; fmc[1] = 0; rdq[1] = 1; wrq[1] = 0;
        active[3] = 1; rq[3] = 1; sel[3] = MS3; fmc[3] = 1; rdq[3] = 1; wrq[3] = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("nomatch_ack", {34'd0, ack[3], ack[1]}, 36'd0);
        end
        rq[1] = 0; rq[3] = 0;
        active = '0;
        tick();

        sw_single_step = 1;
        do_cycle(0, 1, 0, 14'o20, 36'd0, 0, rdat, lat);
        setup_port(1, 1, 0, 14'o20);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("stop_no_ack", {35'd0, ack[1]}, 36'd0);
        end
        sw_single_step = 0;
        sw_restart = 1;
        tick();
        sw_restart = 0;
        wait_bit(1, 0, "restart_ack", n, ok);
        chk("restart_ack_lat", 36'(n), 36'd1);
        rq[1] = 0;
        wait_bit(1, 1, "restart_rs", n, ok);
        chk("restart_data", mb_out[1], 36'o102030405060);
        tick();
        active[1] = 0;

        setup_port(0, 0, 1, 14'o20);
        wait_bit(0, 0, "pwr_ack", n, ok);
        rq[0] = 0;
        tick();
        power = 0; mb_in[0] = 36'o777; wrs[0] = 1;
        tick();
        chk("pwr_off_flags", {28'd0, ack, rs}, 36'd0);
        chk("pwr_off_mb", mb_out[0] | mb_out[1] | mb_out[2] | mb_out[3], 36'd0);
        wrs[0] = 0; power = 1;
        tick();
        active[0] = 0;
        do_cycle(0, 1, 0, 14'o20, 36'd0, 0, rdat, lat);
        chk("pwr_no_store", rdat, 36'o102030405060);

        setup_port(0, 0, 1, 14'd3);
        wait_bit(0, 0, "rst_ack", n, ok);
        rq[0] = 0;
        tick();
        reset = 0; mb_in[0] = 36'o5555; wrs[0] = 1;
        tick();
        chk("rst_flags", {28'd0, ack, rs}, 36'd0);
        chk("rst_mb", mb_out[0] | mb_out[1] | mb_out[2] | mb_out[3], 36'd0);
        wrs[0] = 0; reset = 1;
        active[0] = 0;
        do_cycle(0, 1, 0, 14'd3, 36'd0, 0, rdat, lat);
        chk("rst_first_ack", 36'(lat), 36'd1);
        chk("rst_no_store", rdat, 36'o1235);

        for (int a = 0; a < 8; a++)
            do_cycle(a % 4, 0, 1, 14'(a), {4'($urandom), 32'($urandom)}, 0, rdat, lat);
        for (int i = 0; i < 250; i++) begin
            int op;
            op = $urandom_range(3, 0);
            do_cycle($urandom_range(3, 0), op[0], op[1], 14'($urandom_range(7, 0)),
                     {4'($urandom), 32'($urandom)}, $urandom_range(3, 0), rdat, lat);
            if ($urandom_range(3, 0) == 0) tick();
        end

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
